// File: rtl/stage_seq_pkg.sv
// Shared types and constants for the pipeline-stage sequencer.
// State encoding, dual-rail detector codes and the delay-counter width.
package stage_seq_pkg;

    // Width of the shared settle / replay / watchdog down-counter.
    localparam int CNT_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_WAIT_NULL,
        ST_REPLAY,
        ST_SEND,
        ST_RELEASE,
        ST_FAULT
    } state_t;

    // Dual-rail detector result, packed as {Err1, Err0}.
    typedef logic [1:0] dr_t;

    localparam dr_t DR_NULL    = 2'b00;
    localparam dr_t DR_OK      = 2'b01;
    localparam dr_t DR_ERR     = 2'b10;
    localparam dr_t DR_ILLEGAL = 2'b11;

    // Both rails high is not a legal code; it is treated the same as an error.
    function automatic logic dr_is_error(input dr_t code);
        logic is_err;
        case (code)
            DR_ERR, DR_ILLEGAL: is_err = 1'b1;
            default:            is_err = 1'b0;
        endcase
        return is_err;
    endfunction

    // Only a clean Err0 counts as a pass.
    function automatic logic dr_is_pass(input dr_t code);
        return (code == DR_OK);
    endfunction

endpackage

// File: rtl/stage_seq_if.sv
// Handshake bundle around one pipeline stage: left/right 4-phase channels,
// the stage latch strobe and the 4-phase sample/result pair of the detector.
// master = the sequencer, slave = its surroundings.
interface stage_seq_if;

    logic Lreq;
    logic Lack;
    logic Rreq;
    logic Rack;
    logic latch_en;
    logic sample;
    logic Err1;
    logic Err0;

    modport master (
        input  Lreq,
        input  Rack,
        input  Err1,
        input  Err0,
        output Lack,
        output Rreq,
        output latch_en,
        output sample
    );

    modport slave (
        output Lreq,
        output Rack,
        output Err1,
        output Err0,
        input  Lack,
        input  Rreq,
        input  latch_en,
        input  sample
    );

endinterface

// File: rtl/seq_delay_counter.sv
// Loadable down-counter with a done flag. A load of N-1 makes done rise
// after N cycles in the waiting state; the count parks at zero.
module seq_delay_counter
    import stage_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/stage_seq_ctrl.sv
// Sequencer for one timing-resilient pipeline stage: accepts a token on the
// left handshake, strobes the stage latch, asks the dual-rail detector for a
// verdict, then forwards the token or replays the capture a bounded number
// of times before locking into a sticky fault.
// Optional macro STAGE_SEQ_ERR_TIMEOUT_EN adds a detector watchdog: a silent
// detector in SAMPLE counts as an error, a stuck result in WAIT_NULL faults.
module stage_seq_ctrl
    import stage_seq_pkg::*;
#(
    parameter int SETTLE_CYC  = 2,
    parameter int RETRY_DELAY = 4,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    stage_seq_if.master       bus,
    output logic [3:0]        retry_cnt,
    output logic              fault,
    output logic              busy
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] REPLAY_LOAD  = CNT_W'(RETRY_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       MAX_RETRY_V  = 4'(MAX_RETRY);

    state_t     state_reg;
    state_t     state_next;
    logic       lack_reg;
    logic       lack_next;
    logic       rreq_reg;
    logic       rreq_next;
    logic       verdict_err_reg;
    logic       verdict_err_next;
    logic [3:0] retry_reg;
    logic [3:0] retry_next;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;

    dr_t result;

    assign result = {bus.Err1, bus.Err0};

    // One counter serves SETTLE, REPLAY and the watchdog; they never overlap,
    // so each state loads it on the transition into the next timed state.
    seq_delay_counter #(
        .W(CNT_W)
    ) u_delay (
        .clk      (clk),
        .srst     (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // State and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            lack_reg        <= 1'b0;
            rreq_reg        <= 1'b0;
            verdict_err_reg <= 1'b0;
            retry_reg       <= 4'd0;
        end else begin
            state_reg       <= state_next;
            lack_reg        <= lack_next;
            rreq_reg        <= rreq_next;
            verdict_err_reg <= verdict_err_next;
            retry_reg       <= retry_next;
        end
    end

    // Next-state logic, counter loads and handshake flag updates.
    always_comb begin
        state_next       = state_reg;
        lack_next        = lack_reg;
        rreq_next        = rreq_reg;
        verdict_err_next = verdict_err_reg;
        retry_next       = retry_reg;
        cnt_load         = 1'b0;
        cnt_val          = '0;

        case (state_reg)
            ST_IDLE: begin
                // A downstream that still holds Rack high blocks new tokens.
                if (bus.Lreq && !bus.Rack) begin
                    state_next = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                state_next = ST_SETTLE;
                cnt_load   = 1'b1;
                cnt_val    = SETTLE_LOAD;
            end

            ST_SETTLE: begin
                if (cnt_done) begin
                    state_next = ST_SAMPLE;
                    cnt_load   = 1'b1;
                    cnt_val    = TIMEOUT_LOAD;
                end
            end

            ST_SAMPLE: begin
                if (result != DR_NULL) begin
                    state_next       = ST_WAIT_NULL;
                    verdict_err_next = dr_is_error(result);
                    cnt_load         = 1'b1;
                    cnt_val          = TIMEOUT_LOAD;
                end
`ifdef STAGE_SEQ_ERR_TIMEOUT_EN
                else if (cnt_done) begin
                    // Silent detector: drop sample and take the retry path.
                    state_next       = ST_WAIT_NULL;
                    verdict_err_next = 1'b1;
                    cnt_load         = 1'b1;
                    cnt_val          = TIMEOUT_LOAD;
                end
`endif
            end

            ST_WAIT_NULL: begin
                if (result == DR_NULL) begin
                    if (!verdict_err_reg) begin
                        state_next = ST_SEND;
                        lack_next  = 1'b1;
                        rreq_next  = 1'b1;
                        retry_next = 4'd0;
                    end else if (retry_reg < MAX_RETRY_V) begin
                        state_next = ST_REPLAY;
                        retry_next = retry_reg + 4'd1;
                        cnt_load   = 1'b1;
                        cnt_val    = REPLAY_LOAD;
                    end else begin
                        state_next = ST_FAULT;
                    end
                end
`ifdef STAGE_SEQ_ERR_TIMEOUT_EN
                else if (cnt_done) begin
                    // Detector never returned to null: it cannot be trusted.
                    state_next = ST_FAULT;
                    retry_next = MAX_RETRY_V;
                end
`endif
            end

            ST_REPLAY: begin
                // Lack stays low so upstream keeps its data stable.
                if (cnt_done) begin
                    state_next = ST_CAPTURE;
                end
            end

            ST_SEND: begin
                // Left and right return-to-zero run independently.
                if (!lack_reg && !rreq_reg) begin
                    state_next = ST_RELEASE;
                end else begin
                    if (!bus.Lreq) begin
                        lack_next = 1'b0;
                    end
                    if (bus.Rack) begin
                        rreq_next = 1'b0;
                    end
                end
            end

            ST_RELEASE: begin
                if (!bus.Rack) begin
                    state_next = ST_IDLE;
                end
            end

            ST_FAULT: begin
                // Sticky: only rst leaves this state.
                state_next = ST_FAULT;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.Lack     = lack_reg;
    assign bus.Rreq     = rreq_reg;
    assign bus.latch_en = (state_reg == ST_CAPTURE);
    assign bus.sample   = (state_reg == ST_SAMPLE);
    assign retry_cnt    = retry_reg;
    assign fault        = (state_reg == ST_FAULT);
    assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_FAULT);

endmodule

// File: doc/stage_seq_ctrl.md
Name: stage_seq_ctrl

Overview:
- Synchronous sequencer for one timing-resilient pipeline stage.
- Accepts tokens over a 4-phase left handshake (Lreq/Lack) and pulses the stage latch enable.
- Runs a 4-phase sample handshake with the dual-rail error detector (sample -> Err1/Err0), then either forwards the token over the 4-phase right handshake (Rreq/Rack) or replays the capture.
- Replay count is bounded; when the bound is exceeded, a sticky fault is raised.

Parameters:
- SETTLE_CYC, 2: cycles between the latch_en pulse and sample rising (1..255).
- RETRY_DELAY, 4: idle cycles in REPLAY before re-capture (1..255).
- MAX_RETRY, 3: replays allowed per token before FAULT (1..15).
- TIMEOUT_CYC, 16: detector watchdog limit; used only with ERR_TIMEOUT_EN.

Ports:
- clk  in  1  stage clock
- rst  in  1  synchronous reset, active-high
- Lreq  in  1  left request, 4-phase
- Lack  out  1  left acknowledge
- Rreq  out  1  right request, 4-phase
- Rack  in  1  right acknowledge
- latch_en  out  1  one-cycle stage-latch capture strobe
- sample  out  1  error-detector request, 4-phase
- Err1  in  1  dual-rail detector result: error
- Err0  in  1  dual-rail detector result: no error
- retry_cnt  out  4  replays consumed for the current token
- fault  out  1  sticky retry-exhausted flag
- busy  out  1  high in any state other than IDLE and FAULT

Behaviour:
- Reset:
  - Synchronous, active-high, one clock; also applies mid-operation.
  - All outputs 0; state IDLE; counters 0.
- States: IDLE, CAPTURE, SETTLE, SAMPLE, WAIT_NULL, REPLAY, SEND, RELEASE, FAULT.
- IDLE -> CAPTURE when Lreq=1 and Rack=0. Otherwise hold IDLE, including when Rack is stuck high.
- CAPTURE: latch_en=1 for exactly one cycle, then SETTLE.
- SETTLE: exactly SETTLE_CYC cycles, then SAMPLE.
- SAMPLE: sample=1, held until a valid result is seen.
  - Valid = Err0 xor Err1.
  - Err0=1: pass.
  - Err1=1: error.
  - Err0=Err1=1: illegal; treated as an error.
  - On any valid or illegal result: sample=0 next cycle, go to WAIT_NULL, and latch the verdict.
- WAIT_NULL: wait for Err0=Err1=0, then branch:
  - Pass: SEND; retry_cnt cleared.
  - Error with retry_cnt < MAX_RETRY: REPLAY; retry_cnt increments.
  - Error with retry_cnt = MAX_RETRY: FAULT.
- REPLAY: RETRY_DELAY cycles, then CAPTURE. Lack stays 0 so upstream holds its data.
- SEND:
  - Entry: Lack=1 and Rreq=1 in the same cycle.
  - Lack falls the cycle after Lreq=0 is sampled.
  - Rreq falls the cycle after Rack=1 is sampled.
  - The two events are independent and either may occur first; if both occur in the same cycle, both outputs fall together.
  - Exit to RELEASE when Lack=0 and Rreq=0.
- RELEASE: wait for Rack=0, then IDLE.
- FAULT:
  - fault=1; Lack, Rreq, latch_en and sample all 0.
  - All inputs ignored; exit only by rst.
  - retry_cnt holds MAX_RETRY.
- Reference latency, clean pass with the detector answering in d cycles: Lack/Rreq rise SETTLE_CYC+d+4 cycles after Lreq is first sampled high, plus the cycles spent waiting for null.
- Counters:
  - All counters use a down-counter loaded with N-1.
  - retry_cnt width is 4 bits with no wrap, guaranteed by the MAX_RETRY bound.

Optional Feature:
- Macro: STAGE_SEQ_ERR_TIMEOUT_EN.
- Defined: in SAMPLE, if no valid result arrives within TIMEOUT_CYC cycles, sample drops and the verdict is error (normal retry path).
  - In WAIT_NULL, failure to reach null within TIMEOUT_CYC cycles forces FAULT.
- Undefined: no watchdog; SAMPLE and WAIT_NULL wait indefinitely; the TIMEOUT_CYC parameter is unused.

Decomposition:
- Package stage_seq_pkg:
  - State enum.
  - Dual-rail codes: NULL=2'b00, OK=2'b01 ({Err1,Err0}), ERR=2'b10, ILLEGAL=2'b11.
  - Counter width constant: 8.
- Sub-module seq_delay_counter:
  - Loadable 8-bit down-counter with a done flag.
  - Instantiated once and shared by SETTLE, REPLAY and the timeout, since these are never concurrent.

Test Plan:
- Clean pass (defaults): Lreq rises at cycle 0; detector asserts Err0 two cycles after sample and returns to null one cycle after sample falls.
  - Required: latch_en high only in cycle 1; sample rises at cycle 4; Lack=Rreq=1 at cycle 9; retry_cnt=0.
- Single error: first result Err1, second Err0.
  - Required: exactly two latch_en pulses, separated by the WAIT_NULL time + RETRY_DELAY(4) + SETTLE gap; retry_cnt reads 1 during the replay, then 0 after SEND.
- Retry exhaustion: four consecutive Err1 results.
  - Required: 4 latch_en pulses; fault=1; retry_cnt=3; Lack and Rreq never rise; further Lreq toggles ignored until rst.
- Handshake ordering: Rack rises 10 cycles before Lreq falls, then the reverse order on the next token.
  - Required: Rreq and Lack each fall one cycle after their own trigger; return to IDLE only after Rack=0.
- Illegal and reset cases:
  - Err1=Err0=1: treated as error, retry_cnt=1.
  - rst asserted during SETTLE: next cycle all outputs 0, state IDLE, and a fresh token then completes normally.
- With STAGE_SEQ_ERR_TIMEOUT_EN, detector silent:
  - Required: sample drops after 16 cycles and retry_cnt=1.
  - Without the macro, sample stays high for 100+ cycles.
